// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : BasicTypes / Types (packages)
//  Description : Shared datapath width and the fetch-stage types and constants.
//  Revision    : 1.0 - initial release
// ============================================================================

package BasicTypes;

    localparam int DATA_WIDTH = 32;

    typedef logic [DATA_WIDTH-1:0] DataPath;

endpackage

package Types;

    import BasicTypes::*;

    // Fetch sequencing states; ISSUE is the reset state
    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } FetchStatePath;

    // ADDI x0,x0,0 - what decode sees before anything has been fetched
    localparam DataPath INSN_NOP   = 32'h0000_0013;
    localparam DataPath PC_STEP    = 32'd4;
    localparam DataPath ALIGN_MASK = 32'hFFFF_FFFC;

    // Instruction fetches are word-granular, so the low two bits are dropped
    function automatic DataPath align_word(input DataPath addr);
        return addr & ALIGN_MASK;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Single-outstanding instruction fetch stage. Issues one imem
//                request at a time, holds the fetched word toward decode until
//                accepted, and handles redirects from execute by dropping
//                wrong-path work and restarting at the target.
//  Revision    : 1.0 - initial release
// ============================================================================

module fetch_unit
    import BasicTypes::*;
    import Types::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstN,
    // instruction memory
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemRvalid,
    input  logic [31:0] imemRdata,
    // toward decode
    output logic        fdValid,
    input  logic        fdReady,
    output logic [31:0] fdInsn,
    output logic [31:0] fdPc,
    // from execute
    input  logic        exValid,
    input  logic        brTaken,
    input  logic        jump,
    input  logic [31:0] redirectTarget,
    output logic        flush,
    output logic        targetMisaligned
);

    FetchStatePath state_q, state_d;
    DataPath       pc_q, pc_d;
    DataPath       insn_q, insn_d;
    DataPath       fdpc_q, fdpc_d;
    logic          flush_q;
    logic          misaligned_q;

    logic          w_redirect;

    assign w_redirect = exValid & (brTaken | jump);

    // Next-state and datapath update: a redirect always wins the pc
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        insn_d  = insn_q;
        fdpc_d  = fdpc_q;

        case (state_q)
            ISSUE: begin
                // the request goes out this cycle; if it is already wrong-path,
                // its response must be swallowed in DROP
                state_d = w_redirect ? DROP : WAIT;
            end
            WAIT: begin
                if (imemRvalid) begin
                    if (!w_redirect) begin
                        insn_d  = imemRdata;
                        fdpc_d  = pc_q;
                        pc_d    = pc_q + PC_STEP;
                        state_d = HOLD;
                    end else begin
                        state_d = ISSUE;
                    end
                end else if (w_redirect) begin
                    state_d = DROP;
                end
            end
            HOLD: begin
                if (w_redirect || fdReady) begin
                    state_d = ISSUE;
                end
            end
            DROP: begin
                // the stale response retires the outstanding request
                if (imemRvalid) begin
                    state_d = ISSUE;
                end
            end
            default: state_d = ISSUE;
        endcase

        if (w_redirect) begin
            pc_d = align_word(redirectTarget);
        end
    end

    // State, pc, decode-side registers and the post-redirect pulses
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q      <= ISSUE;
            pc_q         <= RESET_VECTOR;
            insn_q       <= INSN_NOP;
            fdpc_q       <= '0;
            flush_q      <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            insn_q       <= insn_d;
            fdpc_q       <= fdpc_d;
            flush_q      <= w_redirect;
            misaligned_q <= w_redirect & (redirectTarget[1:0] != 2'b00);
        end
    end

    // ISSUE is the reset state, so the request is gated off while in reset
    assign imemReq          = rstN & (state_q == ISSUE);
    assign imemAddr         = pc_q;
    assign fdValid          = (state_q == HOLD);
    assign fdInsn           = insn_q;
    assign fdPc             = fdpc_q;
    assign flush            = flush_q;
    assign targetMisaligned = misaligned_q;

endmodule

`default_nettype wire
